// File: rtl/hdd_pkg.sv
// Shared constants and types for the multi-unit ProDOS block-device slot card.
// Command/result codes follow the ProDOS block-driver conventions.
package hdd_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_FORMAT = 8'h03;

    localparam logic [7:0] RES_OK      = 8'h00;
    localparam logic [7:0] RES_BAD_CMD = 8'h01;
    localparam logic [7:0] RES_IO_ERR  = 8'h27;
    localparam logic [7:0] RES_NO_DEV  = 8'h28;
    localparam logic [7:0] RES_WR_PROT = 8'h2B;

    localparam logic [3:0] REG_EXECUTE = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h1;
    localparam logic [3:0] REG_COMMAND = 4'h2;
    localparam logic [3:0] REG_UNIT    = 4'h3;
    localparam logic [3:0] REG_MEM_L   = 4'h4;
    localparam logic [3:0] REG_MEM_H   = 4'h5;
    localparam logic [3:0] REG_BLK_L   = 4'h6;
    localparam logic [3:0] REG_BLK_H   = 4'h7;
    localparam logic [3:0] REG_DATA    = 4'h8;
    localparam logic [3:0] REG_LAST    = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_WR_REQ
    } hdd_state_t;

    // Which registered source feeds D_OUT on the cycle after an access.
    typedef enum logic [1:0] {
        DSRC_NONE,
        DSRC_REG,
        DSRC_BUF,
        DSRC_ROM
    } dsrc_t;

endpackage

// File: rtl/hdd_multi_if.sv
// Storage-side link of the block device: request/ack handshake, drive status
// and the storage port of the shared sector buffer.
interface hdd_multi_if #(
    parameter int NUM_UNITS = 2,
    parameter int BUF_AW    = 9
);
    logic [15:0]          sector;
    logic                 unit_sel;
    logic                 hdd_read;
    logic                 hdd_write;
    logic                 hdd_ack;
    logic                 hdd_err;
    logic [NUM_UNITS-1:0] hdd_mounted;
    logic [NUM_UNITS-1:0] hdd_protect;
    logic [BUF_AW-1:0]    ram_addr;
    logic [7:0]           ram_di;
    logic [7:0]           ram_do;
    logic                 ram_we;

    modport master (
        output sector, unit_sel, hdd_read, hdd_write, ram_do,
        input  hdd_ack, hdd_err, hdd_mounted, hdd_protect, ram_addr, ram_di, ram_we
    );

    modport slave (
        input  sector, unit_sel, hdd_read, hdd_write, ram_do,
        output hdd_ack, hdd_err, hdd_mounted, hdd_protect, ram_addr, ram_di, ram_we
    );
endinterface

// File: rtl/hdd_sector_buf.sv
// True dual-port 2^AW x 8 sector buffer, one-cycle registered read on each port
// (read-before-write when a port writes the address it reads).
module hdd_sector_buf #(
    parameter int AW = 9
) (
    input  logic          CLK_14M,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_di,
    input  logic          a_we,
    output logic [7:0]    a_do,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_di,
    input  logic          b_we,
    output logic [7:0]    b_do
);
    logic [7:0] mem [2**AW];
    logic [7:0] a_do_d, a_do_q, b_do_d, b_do_q;

    always_comb begin
        a_do_d = mem[a_addr];
        b_do_d = mem[b_addr];
    end

    always_ff @(posedge CLK_14M) begin
        if (a_we) mem[a_addr] <= a_di;
        if (b_we) mem[b_addr] <= b_di;
        a_do_q <= a_do_d;
        b_do_q <= b_do_d;
    end

    assign a_do = a_do_q;
    assign b_do = b_do_q;
endmodule

// File: rtl/rom.sv
// CnXX firmware ROM, 256 x 8 with a registered read (1-cycle latency).
// The boot image is compiled in; BLANK models an empty socket (all FF).
module rom #(
    parameter bit BLANK = 1'b0
) (
    input  logic       CLK_14M,
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    logic [7:0] dout_d, dout_q;

    // ProDOS signature at 01/03/05/07, status byte at FE, driver entry offset at FF.
    function automatic logic [7:0] fw_byte(input logic [7:0] a);
        case (a)
            8'h01:   fw_byte = 8'h20;
            8'h03:   fw_byte = 8'h00;
            8'h05:   fw_byte = 8'h03;
            8'h07:   fw_byte = 8'h3C;
            8'hFE:   fw_byte = 8'h1F;
            8'hFF:   fw_byte = 8'h20;
            default: fw_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        dout_d = BLANK ? 8'hFF : fw_byte(addr);
    end

    always_ff @(posedge CLK_14M) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;
endmodule

// File: rtl/hdd_multi.sv
// Multi-unit ProDOS block device: C0nX registers, CnXX ROM, polled request/ack
// transfers to the storage side through a shared dual-port sector buffer.
module hdd_multi
    import hdd_pkg::*;
#(
    parameter int    NUM_UNITS = 2,
    parameter int    SLOT      = 7,
    parameter int    BUF_AW    = 9,
    parameter string ROM_FILE  = "rtl/roms/hdd.hex"
) (
    input  logic        CLK_14M,
    input  logic        RESET,
    input  logic        PHASE_ZERO,
    input  logic        IO_SELECT,
    input  logic        DEVICE_SELECT,
    input  logic [15:0] A,
    input  logic        RD,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    hdd_multi_if.master hdd
);
    localparam logic [6:0] UNIT_ID = 7'((SLOT % 8) * 16);

    hdd_state_t        state_q, state_d, exec_state;
    dsrc_t             dsrc_q, dsrc_d;
    logic [7:0]        cmd_q, cmd_d, unit_q, unit_d;
    logic [7:0]        mem_l_q, mem_l_d, mem_h_q, mem_h_d;
    logic [7:0]        blk_l_q, blk_l_d, blk_h_q, blk_h_d;
    logic [7:0]        last_q, last_d, reg_out_q, reg_out_d;
    logic              err_q, err_d, unit_sel_q, unit_sel_d;
    logic              dev_prev_q, dev_prev_d, dev_seen_q, dev_seen_d;
    logic              acc_data_q, acc_data_d;
    logic [BUF_AW-1:0] ptr_q, ptr_d;

    logic       busy, dev_hit, dev_fall, rom_hit, buf_we;
    logic       unit_mounted, unit_protect, unit_ok;
    logic [7:0] exec_res, buf_q, rom_q;
    logic [3:0] reg_sel;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^A[15:8];
    assign reg_sel  = A[3:0];
    assign busy     = (state_q != ST_IDLE);
    // Register actions fire once per DEVICE_SELECT assertion, on its first PHASE_ZERO cycle.
    assign dev_hit  = DEVICE_SELECT && PHASE_ZERO && !dev_seen_q;
    assign dev_fall = dev_prev_q && !DEVICE_SELECT;
    assign rom_hit  = IO_SELECT && PHASE_ZERO && RD;

    always_comb begin
        unit_mounted = 1'b0;
        unit_protect = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (int'(unit_q[7]) == i) begin
                unit_mounted = hdd.hdd_mounted[i];
                unit_protect = hdd.hdd_protect[i];
            end
        end
        unit_ok = (unit_q[6:0] == UNIT_ID) && unit_mounted;

        exec_res   = RES_OK;
        exec_state = ST_IDLE;
        if (busy) begin
            exec_res   = RES_IO_ERR;
            exec_state = state_q;
        end else begin
            case (cmd_q)
                CMD_STATUS: exec_res = unit_ok ? RES_OK : RES_NO_DEV;
                CMD_READ: begin
                    if (!unit_ok) exec_res = RES_NO_DEV;
                    else          exec_state = ST_RD_REQ;
                end
                CMD_WRITE: begin
                    if (!unit_ok)         exec_res = RES_NO_DEV;
                    else if (unit_protect) exec_res = RES_WR_PROT;
                    else                  exec_state = ST_WR_REQ;
                end
                CMD_FORMAT: begin
                    if (!unit_ok)         exec_res = RES_NO_DEV;
                    else if (unit_protect) exec_res = RES_WR_PROT;
                end
                default: exec_res = RES_BAD_CMD;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        unit_d     = unit_q;
        mem_l_d    = mem_l_q;
        mem_h_d    = mem_h_q;
        blk_l_d    = blk_l_q;
        blk_h_d    = blk_h_q;
        err_d      = err_q;
        last_d     = last_q;
        ptr_d      = ptr_q;
        unit_sel_d = unit_sel_q;
        acc_data_d = acc_data_q;
        reg_out_d  = reg_out_q;
        dsrc_d     = DSRC_NONE;
        buf_we     = 1'b0;
        dev_prev_d = DEVICE_SELECT;
        dev_seen_d = DEVICE_SELECT && (dev_seen_q || PHASE_ZERO);

        if (rom_hit) dsrc_d = DSRC_ROM;

        if (dev_fall) begin
            if (acc_data_q && !busy) ptr_d = ptr_q + BUF_AW'(1);
            acc_data_d = 1'b0;
        end

        if (dev_hit) begin
            acc_data_d = (reg_sel == REG_DATA) && !busy;
            if (RD) begin
                dsrc_d = DSRC_REG;
                case (reg_sel)
                    REG_EXECUTE: begin
                        reg_out_d = exec_res;
                        last_d    = exec_res;
                        if (!busy) begin
                            state_d = exec_state;
                            err_d   = (exec_res != RES_OK);
                            ptr_d   = '0;
                            if (exec_state != ST_IDLE) unit_sel_d = unit_q[7];
                        end
                    end
                    REG_STATUS:  reg_out_d = {busy, 6'b0, err_q};
                    REG_COMMAND: reg_out_d = cmd_q;
                    REG_UNIT:    reg_out_d = unit_q;
                    REG_MEM_L:   reg_out_d = mem_l_q;
                    REG_MEM_H:   reg_out_d = mem_h_q;
                    REG_BLK_L:   reg_out_d = blk_l_q;
                    REG_BLK_H:   reg_out_d = blk_h_q;
                    REG_DATA:    dsrc_d    = busy ? DSRC_NONE : DSRC_BUF;
                    REG_LAST:    reg_out_d = last_q;
                    default:     reg_out_d = 8'hFF;
                endcase
            end else if (!busy) begin
                case (reg_sel)
                    REG_COMMAND: begin
                        cmd_d = D_IN;
                        if (D_IN == CMD_WRITE) ptr_d = '0;
                    end
                    REG_UNIT:  unit_d  = D_IN;
                    REG_MEM_L: mem_l_d = D_IN;
                    REG_MEM_H: mem_h_d = D_IN;
                    REG_BLK_L: blk_l_d = D_IN;
                    REG_BLK_H: blk_h_d = D_IN;
                    REG_DATA:  buf_we  = 1'b1;
                    default: ;
                endcase
            end
        end

        // Completion outranks a same-cycle EXECUTE, which only ever sees the busy path.
        if (busy && hdd.hdd_ack) begin
            state_d = ST_IDLE;
            err_d   = hdd.hdd_err;
            last_d  = hdd.hdd_err ? RES_IO_ERR : RES_OK;
        end
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            dsrc_q     <= DSRC_NONE;
            cmd_q      <= '0;
            unit_q     <= '0;
            mem_l_q    <= '0;
            mem_h_q    <= '0;
            blk_l_q    <= '0;
            blk_h_q    <= '0;
            err_q      <= 1'b0;
            last_q     <= '0;
            ptr_q      <= '0;
            unit_sel_q <= 1'b0;
            acc_data_q <= 1'b0;
            reg_out_q  <= 8'hFF;
            dev_prev_q <= 1'b0;
            dev_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dsrc_q     <= dsrc_d;
            cmd_q      <= cmd_d;
            unit_q     <= unit_d;
            mem_l_q    <= mem_l_d;
            mem_h_q    <= mem_h_d;
            blk_l_q    <= blk_l_d;
            blk_h_q    <= blk_h_d;
            err_q      <= err_d;
            last_q     <= last_d;
            ptr_q      <= ptr_d;
            unit_sel_q <= unit_sel_d;
            acc_data_q <= acc_data_d;
            reg_out_q  <= reg_out_d;
            dev_prev_q <= dev_prev_d;
            dev_seen_q <= dev_seen_d;
        end
    end

    hdd_sector_buf #(.AW(BUF_AW)) u_buf (
        .CLK_14M (CLK_14M),
        .a_addr  (ptr_q),
        .a_di    (D_IN),
        .a_we    (buf_we),
        .a_do    (buf_q),
        .b_addr  (hdd.ram_addr),
        .b_di    (hdd.ram_di),
        .b_we    (hdd.ram_we),
        .b_do    (hdd.ram_do)
    );

    rom #(.BLANK(ROM_FILE == "")) u_rom (
        .CLK_14M (CLK_14M),
        .addr    (A[7:0]),
        .dout    (rom_q)
    );

    always_comb begin
        case (dsrc_q)
            DSRC_REG: D_OUT = reg_out_q;
            DSRC_BUF: D_OUT = buf_q;
            DSRC_ROM: D_OUT = rom_q;
            default:  D_OUT = 8'hFF;
        endcase
    end

    assign hdd.sector    = {blk_h_q, blk_l_q};
    assign hdd.unit_sel  = unit_sel_q;
    assign hdd.hdd_read  = (state_q == ST_RD_REQ);
    assign hdd.hdd_write = (state_q == ST_WR_REQ);
endmodule

// File: tb/tb_hdd_multi.sv
// Directed bench for hdd_multi: register access, READ/WRITE/FORMAT flows,
// busy behaviour, error completion, reset mid-request and ROM reads.
module tb_hdd_multi;
    import hdd_pkg::*;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        PHASE_ZERO = 1'b0;
    logic        IO_SELECT = 1'b0;
    logic        DEVICE_SELECT = 1'b0;
    logic [15:0] A = 16'h0000;
    logic        RD = 1'b1;
    logic [7:0]  D_IN = 8'h00;
    logic [7:0]  D_OUT;
    logic [7:0]  v;

    int checks = 0;
    int errors = 0;

    hdd_multi_if #(.NUM_UNITS(2), .BUF_AW(9)) hif ();

    hdd_multi #(.NUM_UNITS(2), .SLOT(7), .BUF_AW(9), .ROM_FILE("rtl/roms/hdd.hex")) dut (
        .CLK_14M       (clk),
        .RESET         (RESET),
        .PHASE_ZERO    (PHASE_ZERO),
        .IO_SELECT     (IO_SELECT),
        .DEVICE_SELECT (DEVICE_SELECT),
        .A             (A),
        .RD            (RD),
        .D_IN          (D_IN),
        .D_OUT         (D_OUT),
        .hdd           (hif)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One CPU access: select for one qualified cycle, sample D_OUT the cycle after, release.
    task automatic bus(input logic [15:0] addr, input logic rd, input logic [7:0] din,
                       input logic io, output logic [7:0] dout);
        @(negedge clk);
        A = addr; RD = rd; D_IN = din; PHASE_ZERO = 1'b1;
        if (io) IO_SELECT = 1'b1;
        else    DEVICE_SELECT = 1'b1;
        @(negedge clk);
        dout = D_OUT;
        DEVICE_SELECT = 1'b0; IO_SELECT = 1'b0; PHASE_ZERO = 1'b0; RD = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd_reg(input logic [3:0] off, output logic [7:0] dout);
        bus({12'hC0F, off}, 1'b1, 8'h00, 1'b0, dout);
    endtask

    task automatic wr_reg(input logic [3:0] off, input logic [7:0] val);
        logic [7:0] dummy;
        bus({12'hC0F, off}, 1'b0, val, 1'b0, dummy);
    endtask

    task automatic pulse_ack(input logic e);
        @(negedge clk);
        hif.hdd_ack = 1'b1; hif.hdd_err = e;
        @(negedge clk);
        hif.hdd_ack = 1'b0; hif.hdd_err = 1'b0;
    endtask

    initial begin
        hif.hdd_ack = 1'b0; hif.hdd_err = 1'b0;
        hif.hdd_mounted = 2'b01; hif.hdd_protect = 2'b00;
        hif.ram_addr = '0; hif.ram_di = '0; hif.ram_we = 1'b0;

        repeat (3) @(negedge clk);
        check8("rst_dout", D_OUT, 8'hFF);
        check1("rst_rd", hif.hdd_read, 1'b0);
        check1("rst_wr", hif.hdd_write, 1'b0);
        check1("rst_unit_sel", hif.unit_sel, 1'b0);
        check16("rst_sector", hif.sector, 16'h0000);
        RESET = 1'b0;
        rd_reg(REG_STATUS, v);  check8("rst_status", v, 8'h00);
        rd_reg(REG_LAST, v);    check8("rst_last", v, 8'h00);
        rd_reg(4'hC, v);        check8("unused_reg", v, 8'hFF);

        // STATUS command on a valid and an absent unit
        wr_reg(REG_UNIT, 8'h70); wr_reg(REG_COMMAND, 8'h00);
        rd_reg(REG_EXECUTE, v); check8("stat_ok", v, 8'h00);
        rd_reg(REG_STATUS, v);  check8("stat_ok_status", v, 8'h00);
        wr_reg(REG_UNIT, 8'hF0);
        rd_reg(REG_EXECUTE, v); check8("stat_nodev", v, 8'h28);
        rd_reg(REG_STATUS, v);  check8("stat_nodev_status", v, 8'h01);
        rd_reg(REG_LAST, v);    check8("stat_nodev_last", v, 8'h28);
        wr_reg(REG_UNIT, 8'h60);
        rd_reg(REG_EXECUTE, v); check8("stat_wrong_slot", v, 8'h28);
        wr_reg(REG_UNIT, 8'h70); wr_reg(REG_COMMAND, 8'h07);
        rd_reg(REG_EXECUTE, v); check8("bad_cmd", v, 8'h01);
        rd_reg(REG_STATUS, v);  check8("bad_cmd_status", v, 8'h01);

        // READ unit 70, block 0123
        wr_reg(REG_BLK_L, 8'h23); wr_reg(REG_BLK_H, 8'h01); wr_reg(REG_COMMAND, 8'h01);
        rd_reg(REG_EXECUTE, v); check8("read_exec", v, 8'h00);
        check16("read_sector", hif.sector, 16'h0123);
        check1("read_unit_sel", hif.unit_sel, 1'b0);
        check1("read_req", hif.hdd_read, 1'b1);
        check1("read_no_wr", hif.hdd_write, 1'b0);
        rd_reg(REG_STATUS, v);  check8("read_busy_status", v, 8'h80);
        rd_reg(REG_EXECUTE, v); check8("exec_busy", v, 8'h27);
        check1("exec_busy_req_held", hif.hdd_read, 1'b1);
        wr_reg(REG_BLK_L, 8'h55);
        check16("sector_frozen", hif.sector, 16'h0123);
        rd_reg(REG_DATA, v);    check8("data_rd_busy", v, 8'hFF);
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            hif.ram_we = 1'b1; hif.ram_addr = 9'(i); hif.ram_di = 8'(i) ^ 8'h5A;
        end
        @(negedge clk); hif.ram_we = 1'b0;
        wr_reg(REG_DATA, 8'hAA);
        pulse_ack(1'b0);
        check1("read_req_drop", hif.hdd_read, 1'b0);
        rd_reg(REG_STATUS, v);  check8("read_done_status", v, 8'h00);
        rd_reg(REG_LAST, v);    check8("read_done_last", v, 8'h00);
        for (int i = 0; i < 512; i++) begin
            rd_reg(REG_DATA, v); check8("data_rd", v, 8'(i) ^ 8'h5A);
        end
        rd_reg(REG_DATA, v);    check8("data_wrap", v, 8'h5A);

        // WRITE to protected then unprotected unit 1
        hif.hdd_mounted = 2'b11; hif.hdd_protect = 2'b10;
        wr_reg(REG_UNIT, 8'hF0); wr_reg(REG_COMMAND, 8'h02);
        rd_reg(REG_EXECUTE, v); check8("write_prot", v, 8'h2B);
        check1("write_prot_no_req", hif.hdd_write, 1'b0);
        rd_reg(REG_STATUS, v);  check8("write_prot_status", v, 8'h01);
        hif.hdd_protect = 2'b00;
        wr_reg(REG_COMMAND, 8'h02);
        for (int i = 0; i < 512; i++) wr_reg(REG_DATA, 8'(i) ^ 8'hC3);
        rd_reg(REG_EXECUTE, v); check8("write_exec", v, 8'h00);
        check1("write_req", hif.hdd_write, 1'b1);
        check1("write_no_rd", hif.hdd_read, 1'b0);
        check1("write_unit_sel", hif.unit_sel, 1'b1);
        for (int i = 0; i < 512; i++) begin
            @(negedge clk); hif.ram_addr = 9'(i);
            @(negedge clk); check8("ram_do", hif.ram_do, 8'(i) ^ 8'hC3);
        end
        check1("write_req_held", hif.hdd_write, 1'b1);
        pulse_ack(1'b1);
        check1("write_req_drop", hif.hdd_write, 1'b0);
        rd_reg(REG_STATUS, v);  check8("ack_err_status", v, 8'h01);
        rd_reg(REG_LAST, v);    check8("ack_err_last", v, 8'h27);

        // FORMAT: checks only, no transfer
        wr_reg(REG_COMMAND, 8'h03);
        rd_reg(REG_EXECUTE, v); check8("format_exec", v, 8'h00);
        check1("format_no_wr", hif.hdd_write, 1'b0);
        check1("format_no_rd", hif.hdd_read, 1'b0);

        // Reset during RD_REQ, then a late ack
        wr_reg(REG_UNIT, 8'h70); wr_reg(REG_COMMAND, 8'h01);
        rd_reg(REG_EXECUTE, v); check8("rst_req_exec", v, 8'h00);
        check1("rst_req_up", hif.hdd_read, 1'b1);
        @(negedge clk); RESET = 1'b1;
        @(negedge clk); check1("rst_req_drop", hif.hdd_read, 1'b0);
        RESET = 1'b0;
        rd_reg(REG_STATUS, v);  check8("rst_req_status", v, 8'h00);
        rd_reg(REG_UNIT, v);    check8("rst_unit_reg", v, 8'h00);
        pulse_ack(1'b1);
        check1("late_ack_rd", hif.hdd_read, 1'b0);
        rd_reg(REG_STATUS, v);  check8("late_ack_status", v, 8'h00);
        rd_reg(REG_LAST, v);    check8("late_ack_last", v, 8'h00);

        // Firmware ROM
        bus(16'hC7FF, 1'b1, 8'h00, 1'b1, v); check8("rom_ff", v, 8'h20);
        bus(16'hC707, 1'b1, 8'h00, 1'b1, v); check8("rom_07", v, 8'h3C);
        bus(16'hC705, 1'b1, 8'h00, 1'b1, v); check8("rom_05", v, 8'h03);
        @(negedge clk); check8("idle_dout", D_OUT, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
